// File: rtl/c_fetch_aligner.sv
// Purpose: splits word-aligned fetch data into halfwords and reassembles 16/32-bit instructions.
// Latency: an instruction from a fetch word accepted at cycle N is visible from cycle N+1.
// Backpressure: fetch_ready_o is high only while two or more halfword entries are free; output waits on instr_ready_i.
//
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   flush_i, flush_pc_i         - redirect: drop buffered halfwords, restart at flush_pc_i (bit 0 ignored)
//   fetch_valid_i/_ready_o      - fetch word handshake, fetch_data_i halfword 0 in bits 15:0
//   instr_valid_o/instr_ready_i - instruction handshake
//   instr_o, instr_pc_o         - instruction (compressed form zero-extended) and its address
//   instr_compressed_o          - instr_o holds a 16-bit instruction
//   occupancy_o                 - valid halfwords held
//   illegal_o                   - only with C_ALIGN_ILLEGAL_EN: valid compressed all-zero halfword at head
module c_fetch_aligner #(
  parameter int PC_W     = 32,
  parameter int HB_DEPTH = 4   // power of two, at least 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush_i,
  input  logic [PC_W-1:0]             flush_pc_i,
  input  logic                        fetch_valid_i,
  input  logic [31:0]                 fetch_data_i,
  output logic                        fetch_ready_o,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i,
  output logic [31:0]                 instr_o,
  output logic [PC_W-1:0]             instr_pc_o,
  output logic                        instr_compressed_o,
`ifdef C_ALIGN_ILLEGAL_EN
  output logic                        illegal_o,
`endif
  output logic [$clog2(HB_DEPTH):0]   occupancy_o
);

  localparam int AW = $clog2(HB_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0]   READY_MAX = OW'(HB_DEPTH - 2);
  localparam logic [PC_W-1:0] PC_ALIGN  = {{(PC_W-1){1'b1}}, 1'b0};

  logic [15:0]     hb_q [HB_DEPTH];
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [OW-1:0]   occ_q;
  logic [PC_W-1:0] pc_q;
  // Set after a redirect to an odd halfword: the low halfword of the next
  // fetch word lies before the target and must not enter the buffer.
  logic            skip_q;

  logic [15:0]     head_hw;
  logic [15:0]     next_hw;
  logic            head_comp;
  logic [OW-1:0]   need;
  logic            push_en;
  logic            pop_en;
  logic [OW-1:0]   push_cnt;
  logic [OW-1:0]   pop_cnt;

  always_comb begin
    head_hw   = hb_q[rd_ptr_q];
    next_hw   = hb_q[rd_ptr_q + AW'(1)];
    head_comp = (head_hw[1:0] != 2'b11);
    need      = head_comp ? OW'(1) : OW'(2);

    // A 32-bit head with only its low half present stays invalid until the
    // next word supplies the upper half.
    instr_valid_o = (occ_q >= need);
    // Based on current occupancy only, so a same-cycle pop never frees room early.
    fetch_ready_o = (occ_q <= READY_MAX);

    push_en  = fetch_valid_i && fetch_ready_o;
    pop_en   = instr_valid_o && instr_ready_i;
    push_cnt = push_en ? (skip_q ? OW'(1) : OW'(2)) : OW'(0);
    pop_cnt  = pop_en ? need : OW'(0);

    instr_o            = head_comp ? {16'h0000, head_hw} : {next_hw, head_hw};
    instr_pc_o         = pc_q;
    instr_compressed_o = head_comp;
    occupancy_o        = occ_q;
  end

`ifdef C_ALIGN_ILLEGAL_EN
  assign illegal_o = instr_valid_o && head_comp && (head_hw == 16'h0000);
`endif

  // Control state. Reset beats flush, flush beats both handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      pc_q     <= '0;
      skip_q   <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      pc_q     <= flush_pc_i & PC_ALIGN;
      skip_q   <= flush_pc_i[1];
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(push_cnt);
        skip_q   <= 1'b0;
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(pop_cnt);
        pc_q     <= pc_q + (head_comp ? PC_W'(2) : PC_W'(4));
      end
      occ_q <= occ_q + push_cnt - pop_cnt;
    end
  end

  // Halfword storage; contents beyond occupancy are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && !flush_i && push_en) begin
      if (skip_q) begin
        hb_q[wr_ptr_q] <= fetch_data_i[31:16];
      end else begin
        hb_q[wr_ptr_q]          <= fetch_data_i[15:0];
        hb_q[wr_ptr_q + AW'(1)] <= fetch_data_i[31:16];
      end
    end
  end

endmodule
